// File: rtl/alu_core.sv
// alu_core: W-bit ALU for the CPU datapath, plus a two-bit flag register.
//
// The result path (rslt, sc_o, cnd, pari, zero) is purely combinational.
// The flag register (sc_q, cnd_q) captures sc_o and cnd on flag_we so the
// next instruction can feed them back as sc_i or use them as a branch
// condition. The ALU itself never feeds sc_q back internally; the caller
// routes it to sc_i when chaining is wanted.
//
// Ports:
//   clk      in   clock, rising edge
//   reset    in   synchronous active-high clear of the flag register
//   alu_cmd  in   [4:0] operation select (0..8 defined, 9..31 NOP)
//   inA      in   [W-1:0] operand A
//   inB      in   [W-1:0] operand B
//   sc_i     in   shift/carry input
//   flag_we  in   capture sc_o/cnd into sc_q/cnd_q on the next edge
//   rslt     out  [W-1:0] combinational result
//   sc_o     out  combinational shift/carry out (carry, borrow, shifted bit)
//   cnd      out  combinational compare condition
//   pari     out  XOR-reduce of rslt
//   zero     out  1 when rslt == 0
//   sc_q     out  registered sc_o
//   cnd_q    out  registered cnd
module alu_core #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [4:0]   alu_cmd,
    input  logic [W-1:0] inA,
    input  logic [W-1:0] inB,
    input  logic         sc_i,
    input  logic         flag_we,
    output logic [W-1:0] rslt,
    output logic         sc_o,
    output logic         cnd,
    output logic         pari,
    output logic         zero,
    output logic         sc_q,
    output logic         cnd_q
);

    localparam logic [4:0] CMD_ADD = 5'd0;
    localparam logic [4:0] CMD_SUB = 5'd1;
    localparam logic [4:0] CMD_AND = 5'd2;
    localparam logic [4:0] CMD_XOR = 5'd3;
    localparam logic [4:0] CMD_CMP = 5'd4;
    localparam logic [4:0] CMD_CEX = 5'd5;
    localparam logic [4:0] CMD_LSL = 5'd6;
    localparam logic [4:0] CMD_LSR = 5'd7;
    localparam logic [4:0] CMD_MOV = 5'd8;

    // Operands widened by one bit so the carry/borrow lands in bit W.
    logic [W:0] a_ext;
    logic [W:0] b_ext;
    logic [W:0] c_ext;
    logic [W:0] sum_w;
    logic [W:0] diff_w;

    assign a_ext  = {1'b0, inA};
    assign b_ext  = {1'b0, inB};
    assign c_ext  = {{W{1'b0}}, sc_i};
    assign sum_w  = a_ext + b_ext + c_ext;
    // inA - inB - sc_i spans [-2^W, 2^W-1], which fits exactly in W+1-bit
    // two's complement, so bit W is the sign and therefore the borrow.
    assign diff_w = a_ext - b_ext - c_ext;

    logic [W-1:0] rslt_d;
    logic         sc_d;
    logic         cnd_d;

    always_comb begin
        rslt_d = '0;
        sc_d   = 1'b0;
        cnd_d  = 1'b0;
        case (alu_cmd)
            CMD_ADD: begin
                rslt_d = sum_w[W-1:0];
                sc_d   = sum_w[W];
            end
            CMD_SUB: begin
                rslt_d = diff_w[W-1:0];
                sc_d   = diff_w[W];
            end
            CMD_AND: rslt_d = inA & inB;
            CMD_XOR: rslt_d = inA ^ inB;
            CMD_CMP: begin
                rslt_d = inA;
                cnd_d  = (inA < inB);
            end
            CMD_CEX: begin
                rslt_d = inA;
                cnd_d  = (inA == inB);
            end
            CMD_LSL: begin
                rslt_d = {inA[W-2:0], sc_i};
                sc_d   = inA[W-1];
            end
            CMD_LSR: begin
                rslt_d = {sc_i, inA[W-1:1]};
                sc_d   = inA[0];
            end
            CMD_MOV: rslt_d = inB;
            default: begin
                rslt_d = '0;
                sc_d   = 1'b0;
                cnd_d  = 1'b0;
            end
        endcase
    end

    assign rslt = rslt_d;
    assign sc_o = sc_d;
    assign cnd  = cnd_d;
    assign pari = ^rslt_d;
    assign zero = (rslt_d == '0);

    // Flag register: reset wins over flag_we, otherwise hold.
    logic flag_sc_q;
    logic flag_cnd_q;
    logic flag_sc_d;
    logic flag_cnd_d;

    always_comb begin
        flag_sc_d  = flag_sc_q;
        flag_cnd_d = flag_cnd_q;
        if (flag_we) begin
            flag_sc_d  = sc_d;
            flag_cnd_d = cnd_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            flag_sc_q  <= 1'b0;
            flag_cnd_q <= 1'b0;
        end else begin
            flag_sc_q  <= flag_sc_d;
            flag_cnd_q <= flag_cnd_d;
        end
    end

    assign sc_q  = flag_sc_q;
    assign cnd_q = flag_cnd_q;

endmodule

// File: tb/tb_alu_core.sv
// Testbench for alu_core: directed vectors from the operation table,
// randomized vectors against an arithmetic reference model, and a
// randomized flag-register scoreboard with interleaved reset/flag_we.
module tb_alu_core;

    localparam int W   = 8;
    localparam int MOD = 1 << W;

    logic         clk;
    logic         reset;
    logic [4:0]   alu_cmd;
    logic [W-1:0] inA;
    logic [W-1:0] inB;
    logic         sc_i;
    logic         flag_we;
    logic [W-1:0] rslt;
    logic         sc_o;
    logic         cnd;
    logic         pari;
    logic         zero;
    logic         sc_q;
    logic         cnd_q;

    int checks = 0;
    int errors = 0;

    alu_core #(.W(W)) dut (
        .clk     (clk),
        .reset   (reset),
        .alu_cmd (alu_cmd),
        .inA     (inA),
        .inB     (inB),
        .sc_i    (sc_i),
        .flag_we (flag_we),
        .rslt    (rslt),
        .sc_o    (sc_o),
        .cnd     (cnd),
        .pari    (pari),
        .zero    (zero),
        .sc_q    (sc_q),
        .cnd_q   (cnd_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: plain integer arithmetic on the operation table.
    function automatic void model(input int cmd, input int a, input int b, input int c,
                                  output int r, output int sco, output int cn);
        r = 0; sco = 0; cn = 0;
        case (cmd)
            0: begin r = (a + b + c) % MOD; sco = (a + b + c >= MOD) ? 1 : 0; end
            1: begin r = (a - b - c + MOD) % MOD; sco = (a < b + c) ? 1 : 0; end
            2: r = a & b;
            3: r = a ^ b;
            4: begin r = a; cn = (a < b) ? 1 : 0; end
            5: begin r = a; cn = (a == b) ? 1 : 0; end
            6: begin r = (a * 2 + c) % MOD; sco = (a >= MOD / 2) ? 1 : 0; end
            7: begin r = a / 2 + c * (MOD / 2); sco = a % 2; end
            8: r = b;
            default: ;
        endcase
    endfunction

    function automatic int parity_of(input int v);
        int ones = 0;
        for (int i = 0; i < W; i++) ones += (v >> i) & 1;
        return ones % 2;
    endfunction

    // Drive one operation mid-cycle and let the combinational path settle.
    task automatic apply(input int cmd, input int a, input int b, input int c);
        @(negedge clk);
        alu_cmd = cmd[4:0];
        inA     = a[W-1:0];
        inB     = b[W-1:0];
        sc_i    = c[0];
        #1;
    endtask

    task automatic test_reset;
        @(negedge clk);
        reset = 1'b1; flag_we = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if (sc_q !== 1'b0) begin errors++; $display("FAIL reset_sc_q: got %b expected 0", sc_q); end
        checks++;
        if (cnd_q !== 1'b0) begin errors++; $display("FAIL reset_cnd_q: got %b expected 0", cnd_q); end
    endtask

    task automatic test_add;
        apply(0, 'h04, 'h03, 0);
        checks++;
        if ({rslt, sc_o, zero, pari} !== {8'h07, 1'b0, 1'b0, 1'b1}) begin
            errors++; $display("FAIL add_small: got r=%h sc=%b z=%b p=%b expected r=07 sc=0 z=0 p=1", rslt, sc_o, zero, pari);
        end
        apply(0, 'hCC, 'h33, 1);
        checks++;
        if ({rslt, sc_o, zero, pari} !== {8'h00, 1'b1, 1'b1, 1'b0}) begin
            errors++; $display("FAIL add_carry: got r=%h sc=%b z=%b p=%b expected r=00 sc=1 z=1 p=0", rslt, sc_o, zero, pari);
        end
    endtask

    task automatic test_sub;
        apply(1, 'hCC, 'h33, 0);
        checks++;
        if ({rslt, sc_o} !== {8'h99, 1'b0}) begin errors++; $display("FAIL sub_plain: got r=%h sc=%b expected r=99 sc=0", rslt, sc_o); end
        apply(1, 'hCC, 'h33, 1);
        checks++;
        if ({rslt, sc_o} !== {8'h98, 1'b0}) begin errors++; $display("FAIL sub_borrow_in: got r=%h sc=%b expected r=98 sc=0", rslt, sc_o); end
        apply(1, 'h01, 'h02, 0);
        checks++;
        if ({rslt, sc_o} !== {8'hFF, 1'b1}) begin errors++; $display("FAIL sub_underflow: got r=%h sc=%b expected r=ff sc=1", rslt, sc_o); end
    endtask

    task automatic test_logic;
        apply(2, 'h01, 'h01, 0);
        checks++;
        if (rslt !== 8'h01) begin errors++; $display("FAIL and: got %h expected 01", rslt); end
        apply(3, 'h01, 'h01, 0);
        checks++;
        if ({rslt, zero} !== {8'h00, 1'b1}) begin errors++; $display("FAIL xor: got r=%h z=%b expected r=00 z=1", rslt, zero); end
        apply(4, 'h03, 'h01, 0);
        checks++;
        if ({cnd, rslt} !== {1'b0, 8'h03}) begin errors++; $display("FAIL cmp_ge: got cnd=%b r=%h expected cnd=0 r=03", cnd, rslt); end
        apply(4, 'h01, 'h03, 0);
        checks++;
        if (cnd !== 1'b1) begin errors++; $display("FAIL cmp_lt: got cnd=%b expected 1", cnd); end
        apply(5, 'h03, 'h01, 0);
        checks++;
        if (cnd !== 1'b0) begin errors++; $display("FAIL cex_ne: got cnd=%b expected 0", cnd); end
        apply(5, 'h05, 'h05, 0);
        checks++;
        if ({cnd, rslt} !== {1'b1, 8'h05}) begin errors++; $display("FAIL cex_eq: got cnd=%b r=%h expected cnd=1 r=05", cnd, rslt); end
        apply(8, 'hA5, 'h01, 0);
        checks++;
        if (rslt !== 8'h01) begin errors++; $display("FAIL mov: got %h expected 01", rslt); end
        apply(9, 'hFF, 'hFF, 1);
        checks++;
        if ({rslt, sc_o, cnd, zero, pari} !== {8'h00, 1'b0, 1'b0, 1'b1, 1'b0}) begin
            errors++; $display("FAIL nop: got r=%h sc=%b cnd=%b z=%b p=%b expected r=00 sc=0 cnd=0 z=1 p=0", rslt, sc_o, cnd, zero, pari);
        end
    endtask

    task automatic test_shifts;
        apply(6, 'h03, 0, 1);
        checks++;
        if ({rslt, sc_o} !== {8'h07, 1'b0}) begin errors++; $display("FAIL lsl_c1: got r=%h sc=%b expected r=07 sc=0", rslt, sc_o); end
        apply(6, 'h03, 0, 0);
        checks++;
        if ({rslt, sc_o} !== {8'h06, 1'b0}) begin errors++; $display("FAIL lsl_c0: got r=%h sc=%b expected r=06 sc=0", rslt, sc_o); end
        apply(7, 'h03, 0, 1);
        checks++;
        if ({rslt, sc_o} !== {8'h81, 1'b1}) begin errors++; $display("FAIL lsr_c1: got r=%h sc=%b expected r=81 sc=1", rslt, sc_o); end
        apply(7, 'h03, 0, 0);
        checks++;
        if ({rslt, sc_o} !== {8'h01, 1'b1}) begin errors++; $display("FAIL lsr_c0: got r=%h sc=%b expected r=01 sc=1", rslt, sc_o); end
        apply(6, 'h80, 0, 0);
        checks++;
        if ({rslt, sc_o} !== {8'h00, 1'b1}) begin errors++; $display("FAIL lsl_msb: got r=%h sc=%b expected r=00 sc=1", rslt, sc_o); end
    endtask

    task automatic test_flags;
        apply(0, 'hCC, 'h33, 1);
        flag_we = 1'b1;
        @(negedge clk);
        flag_we = 1'b0;
        checks++;
        if ({sc_q, cnd_q} !== 2'b10) begin errors++; $display("FAIL flag_capture_add: got sc_q=%b cnd_q=%b expected 1 0", sc_q, cnd_q); end
        apply(4, 'h01, 'h03, 0);
        flag_we = 1'b1;
        @(negedge clk);
        flag_we = 1'b0;
        checks++;
        if ({sc_q, cnd_q} !== 2'b01) begin errors++; $display("FAIL flag_capture_cmp: got sc_q=%b cnd_q=%b expected 0 1", sc_q, cnd_q); end
        // Ops that would change both flags must not disturb the register.
        apply(0, 'hFF, 'h01, 0);
        apply(4, 'h09, 'h02, 0);
        apply(1, 'h00, 'h01, 0);
        @(negedge clk);
        checks++;
        if ({sc_q, cnd_q} !== 2'b01) begin errors++; $display("FAIL flag_hold: got sc_q=%b cnd_q=%b expected 0 1", sc_q, cnd_q); end
        apply(0, 'hCC, 'h33, 1);
        flag_we = 1'b1;
        reset   = 1'b1;
        @(negedge clk);
        flag_we = 1'b0;
        reset   = 1'b0;
        checks++;
        if ({sc_q, cnd_q} !== 2'b00) begin errors++; $display("FAIL reset_priority: got sc_q=%b cnd_q=%b expected 0 0", sc_q, cnd_q); end
    endtask

    task automatic test_random_ops;
        int a, b, c, cmd, r, sco, cn;
        for (int n = 0; n < 400; n++) begin
            a   = $urandom_range(0, MOD - 1);
            b   = ($urandom_range(0, 7) == 0) ? a : $urandom_range(0, MOD - 1);
            c   = $urandom_range(0, 1);
            cmd = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 8);
            apply(cmd, a, b, c);
            model(cmd, a, b, c, r, sco, cn);
            checks++;
            if (rslt !== r[W-1:0] || sc_o !== sco[0] || cnd !== cn[0] ||
                pari !== parity_of(r) % 2 || zero !== (r == 0)) begin
                errors++;
                $display("FAIL random_op cmd=%0d a=%h b=%h c=%0d: got r=%h sc=%b cnd=%b p=%b z=%b expected r=%h sc=%0d cnd=%0d p=%0d z=%0d",
                         cmd, a, b, c, rslt, sc_o, cnd, pari, zero, r[W-1:0], sco, cn, parity_of(r), (r == 0));
            end
        end
    endtask

    task automatic test_back_to_back;
        int a, b, c, cmd, r, sco, cn;
        int exp_sc, exp_cnd;
        logic rst_now, we_now;
        exp_sc = 0; exp_cnd = 0;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (n > 0) begin
                checks++;
                if (sc_q !== exp_sc[0] || cnd_q !== exp_cnd[0]) begin
                    errors++;
                    $display("FAIL flag_scoreboard step %0d: got sc_q=%b cnd_q=%b expected %0d %0d", n, sc_q, cnd_q, exp_sc, exp_cnd);
                end
            end
            a   = $urandom_range(0, MOD - 1);
            b   = $urandom_range(0, MOD - 1);
            c   = $urandom_range(0, 1);
            cmd = $urandom_range(0, 9);
            rst_now = (n == 0) || ($urandom_range(0, 15) == 0);
            we_now  = ($urandom_range(0, 1) == 1);
            alu_cmd = cmd[4:0];
            inA     = a[W-1:0];
            inB     = b[W-1:0];
            sc_i    = c[0];
            reset   = rst_now;
            flag_we = we_now;
            model(cmd, a, b, c, r, sco, cn);
            if (rst_now) begin
                exp_sc = 0; exp_cnd = 0;
            end else if (we_now) begin
                exp_sc = sco; exp_cnd = cn;
            end
        end
        @(negedge clk);
        reset = 1'b0; flag_we = 1'b0;
        checks++;
        if (sc_q !== exp_sc[0] || cnd_q !== exp_cnd[0]) begin
            errors++;
            $display("FAIL flag_scoreboard final: got sc_q=%b cnd_q=%b expected %0d %0d", sc_q, cnd_q, exp_sc, exp_cnd);
        end
    endtask

    initial begin
        reset = 1'b0; flag_we = 1'b0;
        alu_cmd = '0; inA = '0; inB = '0; sc_i = 1'b0;
        test_reset();
        test_add();
        test_sub();
        test_logic();
        test_shifts();
        test_flags();
        test_random_ops();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_core.md
Name: alu_core

Overview:
- 8-bit ALU for the project CPU datapath.
- Combinational result path computes rslt and status flags (sc_o, cnd, pari, zero) from alu_cmd, inA, inB and the shift/carry input sc_i.
- A small clocked flag register captures sc_o and cnd on request, so the next instruction can use them as sc_i and as a branch condition.

Parameters:
- W, 8, datapath width. All tests use 8; the implementation must be width-generic.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  synchronous, active-high; clears the flag register.
- alu_cmd  input  5  operation select.
- inA  input  W  operand A.
- inB  input  W  operand B.
- sc_i  input  1  shift/carry input.
- flag_we  input  1  when 1, sc_o and cnd are captured into the flag register at the next rising clk edge.
- rslt  output  W  combinational result.
- sc_o  output  1  combinational shift/carry output.
- cnd  output  1  combinational compare condition.
- pari  output  1  combinational parity of rslt (XOR-reduce).
- zero  output  1  combinational; 1 when rslt == 0.
- sc_q  output  1  registered sc_o.
- cnd_q  output  1  registered cnd.

Behaviour:
- Result path is purely combinational and has zero-cycle latency: outputs follow inputs within the same cycle. There are no clocked elements in this path.
- Default values for every op, unless overridden below: sc_o=0, cnd=0.
- alu_cmd encodings (unsigned):
  - 0 ADD: {sc_o,rslt} = inA + inB + sc_i, computed in W+1 bits; sc_o is the carry out.
  - 1 SUB: rslt = (inA - inB - sc_i) mod 2^W. sc_o = borrow, i.e. 1 if inA < inB + sc_i (unsigned, W+1-bit compare).
  - 2 AND: rslt = inA & inB.
  - 3 XOR: rslt = inA ^ inB.
  - 4 CMP: cnd = (inA < inB), unsigned; rslt = inA.
  - 5 CEX: cnd = (inA == inB); rslt = inA.
  - 6 LSL: rslt = {inA[W-2:0], sc_i}; sc_o = inA[W-1].
  - 7 LSR: rslt = {sc_i, inA[W-1:1]}; sc_o = inA[0].
  - 8 MOV: rslt = inB; inA ignored.
  - 9..31 reserved/NOP: rslt = 0, sc_o = 0, cnd = 0. Consequently zero=1 and pari=0.
- pari = ^rslt and zero = (rslt == 0), evaluated for every op including CMP, CEX and NOP.
- Flag register, on rising clk:
  - reset=1: sc_q <= 0, cnd_q <= 0. Reset has priority over flag_we.
  - else flag_we=1: sc_q <= sc_o, cnd_q <= cnd.
  - else: hold.
- sc_q and cnd_q are 0 from the first edge with reset asserted and are unknown before it. Reset has no effect on the combinational outputs.
- No internal feedback: sc_i is always the external port. The caller routes sc_q to sc_i when chaining is wanted.

Test Plan:
- ADD: inA=0x04, inB=0x03, sc_i=0 -> rslt=0x07, sc_o=0, zero=0, pari=1. Then inA=0xCC, inB=0x33, sc_i=1 -> rslt=0x00, sc_o=1, zero=1, pari=0.
- SUB: inA=0xCC, inB=0x33, sc_i=0 -> rslt=0x99, sc_o=0. With sc_i=1 -> rslt=0x98, sc_o=0. Then inA=0x01, inB=0x02, sc_i=0 -> rslt=0xFF, sc_o=1.
- Logic, compare and move:
  - AND 0x01,0x01 -> 0x01.
  - XOR 0x01,0x01 -> 0x00, zero=1.
  - CMP 0x03,0x01 -> cnd=0; CMP 0x01,0x03 -> cnd=1.
  - CEX 0x03,0x01 -> cnd=0; CEX 0x05,0x05 -> cnd=1.
  - MOV inB=0x01 -> rslt=0x01.
  - cmd=9 -> rslt=0x00, zero=1.
- Shifts, inA=0x03:
  - LSL sc_i=1 -> 0x07, sc_o=0; sc_i=0 -> 0x06, sc_o=0.
  - LSR sc_i=1 -> 0x81, sc_o=1; sc_i=0 -> 0x01, sc_o=1.
  - LSL inA=0x80 -> 0x00, sc_o=1.
- Flag register:
  - Assert reset for one clk -> sc_q=0, cnd_q=0.
  - ADD 0xCC+0x33+1 with flag_we=1, one clk -> sc_q=1.
  - flag_we=0 with changing ops -> sc_q and cnd_q hold.
  - reset=1 and flag_we=1 on the same edge -> both 0.
